// File: rtl/wb_pkg.sv
// Shared types for the register-writeback stage:
// source selects, FSM states and the UART length clamp.
package wb_pkg;

   localparam int WB_SEL_W = 3;

   typedef enum logic [WB_SEL_W-1:0] {
      WB_NONE = 3'd0,
      WB_MEM  = 3'd1,
      WB_ALU  = 3'd2,
      WB_LINK = 3'd3,
      WB_UART = 3'd4,
      WB_FPU  = 3'd5
   } wb_sel_e;

   typedef enum logic [1:0] {
      IDLE,
      RX,
      COMMIT
   } wb_state_e;

   // A length of 0 means one byte; anything past a full word is a full word.
   function automatic int clamp_len(input int len, input int max_len);
      if (len == 0) return 1;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bus between the pipeline/UART side (master) and the
// writeback stage (slave).
interface writeback_stage_if
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 2
);
   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int LEN_W = $clog2(BYTES_PER_WORD + 1);

   logic                  wb_valid;
   logic [WB_SEL_W-1:0]   wb_sel;
   logic [LEN_W-1:0]      rx_len;
   logic [DATA_WIDTH-1:0] read_data;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [DATA_WIDTH-1:0] fpu_result;
   logic [PC_WIDTH-1:0]   pc;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  reg_we;
   logic [DATA_WIDTH-1:0] data;
   logic                  pc_enable;
   logic                  timeout_err;

   modport slave (
      input  wb_valid, wb_sel, rx_len, read_data,
      input  alu_result, fpu_result, pc,
      input  rx_data, rx_valid,
      output rx_ready, reg_we, data, pc_enable, timeout_err
   );

   modport master (
      output wb_valid, wb_sel, rx_len, read_data,
      output alu_result, fpu_result, pc,
      output rx_data, rx_valid,
      input  rx_ready, reg_we, data, pc_enable, timeout_err
   );

endinterface

// File: rtl/uart_word_assembler.sv
// Packs UART bytes little-endian into one word, with
// length clamp and optional inter-byte timeout.
module uart_word_assembler
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int LEN_W          = $clog2(BYTES_PER_WORD + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  active,
   input  logic                  hs,
   input  logic [7:0]            rx_byte,
   input  logic [LEN_W-1:0]      rx_len,
   output logic                  done,
   output logic                  timed_out,
   output logic [DATA_WIDTH-1:0] word
);
   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;

   // word already includes the byte handshaking this cycle
   always_comb begin
      word = acc_q;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (hs && cnt_q == LEN_W'(i)) word[8*i +: 8] = rx_byte;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      len_d  = len_q;
      acc_d  = acc_q;
      tcnt_d = tcnt_q;
      if (start) begin
         cnt_d  = '0;
         acc_d  = '0;
         tcnt_d = '0;
         len_d  = LEN_W'(clamp_len(int'(rx_len), BYTES_PER_WORD));
      end else if (hs) begin
         cnt_d  = cnt_q + LEN_W'(1);
         acc_d  = word;
         tcnt_d = '0;
      end else if (active && TIMEOUT_CYCLES > 0) begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end

   assign done = hs && (cnt_q == len_q - LEN_W'(1));
   assign timed_out = (TIMEOUT_CYCLES > 0) && active && !hs &&
                      (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         len_q  <= '0;
         acc_q  <= '0;
         tcnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         len_q  <= len_d;
         acc_q  <= acc_d;
         tcnt_q <= tcnt_d;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Register-writeback stage: source mux plus a UART
// receive path that stalls fetch until the word is built.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 2,
   parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 0
) (
   input logic CLK,
   input logic reset,
   writeback_stage_if.slave bus
);
   localparam int LEN_W = $clog2(BYTES_PER_WORD + 1);

   wb_state_e             state_q, state_d;
   logic                  reg_we_q, reg_we_d;
   logic                  pc_enable_q, pc_enable_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic                  hs, start, active;
   logic                  done, timed_out;
   logic [DATA_WIDTH-1:0] word;
   logic [PC_WIDTH-1:0]   pc_inc;

   assign active = (state_q == RX);
   assign hs     = bus.rx_valid && active;
   assign start  = (state_q == IDLE) && bus.wb_valid &&
                   (bus.wb_sel == WB_UART);
   assign pc_inc = bus.pc + PC_WIDTH'(1);

   uart_word_assembler #(
      .DATA_WIDTH     (DATA_WIDTH),
      .BYTES_PER_WORD (BYTES_PER_WORD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .LEN_W          (LEN_W)
   ) u_asm (
      .clk       (CLK),
      .rst       (reset),
      .start     (start),
      .active    (active),
      .hs        (hs),
      .rx_byte   (bus.rx_data),
      .rx_len    (bus.rx_len),
      .done      (done),
      .timed_out (timed_out),
      .word      (word)
   );

   always_comb begin
      state_d       = state_q;
      reg_we_d      = 1'b0;
      timeout_err_d = 1'b0;
      data_d        = data_q;
      pc_enable_d   = pc_enable_q;
      unique case (state_q)
         IDLE: begin
            if (bus.wb_valid) begin
               reg_we_d = 1'b1;
               case (wb_sel_e'(bus.wb_sel))
                  WB_MEM:  data_d = bus.read_data;
                  WB_ALU:  data_d = bus.alu_result;
                  WB_LINK: data_d = DATA_WIDTH'(pc_inc);
                  WB_FPU:  data_d = bus.fpu_result;
                  WB_UART: begin
                     reg_we_d    = 1'b0;
                     state_d     = RX;
                     pc_enable_d = 1'b0;
                  end
                  default: reg_we_d = 1'b0;
               endcase
            end
         end
         RX: begin
            if (done || timed_out) begin
               state_d       = COMMIT;
               reg_we_d      = 1'b1;
               data_d        = word;
               pc_enable_d   = 1'b1;
               timeout_err_d = timed_out;
            end
         end
         COMMIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         reg_we_q      <= 1'b0;
         pc_enable_q   <= 1'b1;
         timeout_err_q <= 1'b0;
         data_q        <= '0;
      end else begin
         state_q       <= state_d;
         reg_we_q      <= reg_we_d;
         pc_enable_q   <= pc_enable_d;
         timeout_err_q <= timeout_err_d;
         data_q        <= data_d;
      end
   end

   // The frozen pipeline must never present a new instruction mid-read.
   always_ff @(posedge CLK) begin
      if (!reset && bus.wb_valid) assert (state_q == IDLE);
   end

   assign bus.rx_ready    = active;
   assign bus.reg_we      = reg_we_q;
   assign bus.data        = data_q;
   assign bus.pc_enable   = pc_enable_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: random sources and
// UART reads checked against a byte-level reference model.
module tb_writeback_stage;

   localparam int DW = 32;
   localparam int PW = 2;
   localparam int TO = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   writeback_stage_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus();

   writeback_stage #(
      .DATA_WIDTH     (DW),
      .PC_WIDTH       (PW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_data = '0;

   function automatic bit model_src(input int sel, input logic [31:0] rd,
                                    input logic [31:0] alu, input logic [31:0] fpu,
                                    input logic [1:0] p, output logic [31:0] v);
      v = '0;
      case (sel)
         1: v = rd;
         2: v = alu;
         3: v = 32'((int'(p) + 1) % 4);
         5: v = fpu;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic drive_idle();
      bus.wb_valid   = 1'b0;
      bus.wb_sel     = '0;
      bus.rx_len     = '0;
      bus.rx_valid   = 1'b0;
      bus.rx_data    = '0;
      bus.read_data  = '0;
      bus.alu_result = '0;
      bus.fpu_result = '0;
      bus.pc         = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.reg_we !== 1'b0 || bus.data !== 32'h0 || bus.pc_enable !== 1'b1 ||
          bus.timeout_err !== 1'b0 || bus.rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset got we=%b data=%h pce=%b to=%b rdy=%b want 0 0 1 0 0",
                  bus.reg_we, bus.data, bus.pc_enable, bus.timeout_err, bus.rx_ready);
      end
      rst = 1'b0;
      exp_data = '0;
   endtask

   task automatic test_alu();
      @(negedge clk);
      bus.wb_valid = 1'b1;
      bus.wb_sel = 3'd2;
      bus.alu_result = 32'h1234_5678;
      @(negedge clk);
      bus.wb_valid = 1'b0;
      exp_data = 32'h1234_5678;
      checks++;
      if (bus.reg_we !== 1'b1 || bus.data !== exp_data) begin
         errors++;
         $display("FAIL alu got we=%b data=%h want 1 %h", bus.reg_we, bus.data, exp_data);
      end
      @(negedge clk);
      checks++;
      if (bus.reg_we !== 1'b0 || bus.data !== exp_data) begin
         errors++;
         $display("FAIL alu_hold got we=%b data=%h want 0 %h", bus.reg_we, bus.data, exp_data);
      end
   endtask

   task automatic test_link();
      logic [1:0] pcs [2];
      pcs[0] = 2'b11;
      pcs[1] = 2'b01;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.wb_valid = 1'b1;
         bus.wb_sel = 3'd3;
         bus.pc = pcs[i];
         void'(model_src(3, '0, '0, '0, pcs[i], exp_data));
         @(negedge clk);
         bus.wb_valid = 1'b0;
         checks++;
         if (bus.reg_we !== 1'b1 || bus.data !== exp_data) begin
            errors++;
            $display("FAIL link pc=%0d got we=%b data=%h want 1 %h",
                     pcs[i], bus.reg_we, bus.data, exp_data);
         end
      end
   endtask

   task automatic test_sources_random();
      int sel;
      bit wr;
      logic [31:0] v;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         sel = $urandom_range(0, 7);
         if (sel == 4) sel = 5;
         bus.wb_valid   = 1'b1;
         bus.wb_sel     = 3'(sel);
         bus.read_data  = $urandom;
         bus.alu_result = $urandom;
         bus.fpu_result = $urandom;
         bus.pc         = 2'($urandom);
         wr = model_src(sel, bus.read_data, bus.alu_result, bus.fpu_result, bus.pc, v);
         if (wr) exp_data = v;
         @(negedge clk);
         bus.wb_valid = 1'b0;
         checks++;
         if (bus.reg_we !== wr || bus.data !== exp_data) begin
            errors++;
            $display("FAIL src sel=%0d got we=%b data=%h want %b %h",
                     sel, bus.reg_we, bus.data, wr, exp_data);
         end
      end
   endtask

   task automatic test_back_to_back();
      int sel;
      bit wr;
      bit prev_wr = 1'b0;
      logic [31:0] v;
      @(negedge clk);
      for (int i = 0; i <= 20; i++) begin
         if (i > 0) begin
            checks++;
            if (bus.reg_we !== prev_wr || bus.data !== exp_data) begin
               errors++;
               $display("FAIL b2b step=%0d got we=%b data=%h want %b %h",
                        i, bus.reg_we, bus.data, prev_wr, exp_data);
            end
         end
         if (i == 20) begin
            bus.wb_valid = 1'b0;
         end else begin
            sel = (i == 7) ? 0 : $urandom_range(1, 3);
            bus.wb_valid   = 1'b1;
            bus.wb_sel     = 3'(sel);
            bus.read_data  = $urandom;
            bus.alu_result = $urandom;
            bus.pc         = 2'($urandom);
            wr = model_src(sel, bus.read_data, bus.alu_result, bus.fpu_result, bus.pc, v);
            if (wr) exp_data = v;
            prev_wr = wr;
            @(negedge clk);
         end
      end
   endtask

   task automatic uart_xfer(input logic [2:0] len_in, input logic [7:0] b [4],
                            input int nsend, input int gap, input string name);
      int L;
      int used;
      int n;
      bit tmo;
      bit stall_bad = 1'b0;
      logic [31:0] w = '0;
      L = (len_in == 0) ? 1 : ((len_in > 4) ? 4 : int'(len_in));
      used = (nsend < L) ? nsend : L;
      tmo = (nsend < L);
      for (int i = 0; i < used; i++) w = w | (32'(b[i]) << (8 * i));
      @(negedge clk);
      bus.wb_valid = 1'b1;
      bus.wb_sel = 3'd4;
      bus.rx_len = len_in;
      @(negedge clk);
      bus.wb_valid = 1'b0;
      bus.wb_sel = '0;
      checks++;
      if (bus.pc_enable !== 1'b0 || bus.rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s entry got pce=%b rdy=%b want 0 1", name, bus.pc_enable, bus.rx_ready);
      end
      for (int i = 0; i < used; i++) begin
         repeat (gap) begin
            @(negedge clk);
            if (bus.pc_enable !== 1'b0 || bus.reg_we !== 1'b0) stall_bad = 1'b1;
         end
         bus.rx_valid = 1'b1;
         bus.rx_data = b[i];
         @(negedge clk);
         bus.rx_valid = 1'b0;
         if (!tmo && i == L - 1) begin
            checks++;
            if (bus.reg_we !== 1'b1 || bus.data !== w || bus.pc_enable !== 1'b1 ||
                bus.timeout_err !== 1'b0 || bus.rx_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s commit got we=%b data=%h pce=%b to=%b rdy=%b want 1 %h 1 0 0",
                        name, bus.reg_we, bus.data, bus.pc_enable, bus.timeout_err,
                        bus.rx_ready, w);
            end
         end else if (bus.pc_enable !== 1'b0 || bus.reg_we !== 1'b0) begin
            stall_bad = 1'b1;
         end
      end
      if (tmo) begin
         n = 1;
         while (bus.reg_we !== 1'b1 && n < 40) begin
            if (bus.pc_enable !== 1'b0) stall_bad = 1'b1;
            n++;
            @(negedge clk);
         end
         checks++;
         if (n != TO + 1 || bus.data !== w || bus.timeout_err !== 1'b1 ||
             bus.pc_enable !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout got cycle=%0d data=%h to=%b pce=%b want %0d %h 1 1",
                     name, n, bus.data, bus.timeout_err, bus.pc_enable, TO + 1, w);
         end
      end
      checks++;
      if (stall_bad) begin
         errors++;
         $display("FAIL %s stall got early pc_enable/reg_we want pce=0 we=0", name);
      end
      exp_data = w;
      @(negedge clk);
      checks++;
      if (bus.reg_we !== 1'b0 || bus.timeout_err !== 1'b0 || bus.rx_ready !== 1'b0 ||
          bus.data !== exp_data) begin
         errors++;
         $display("FAIL %s after got we=%b to=%b rdy=%b data=%h want 0 0 0 %h",
                  name, bus.reg_we, bus.timeout_err, bus.rx_ready, bus.data, exp_data);
      end
   endtask

   task automatic test_uart_word();
      logic [7:0] b [4];
      b[0] = 8'hEF; b[1] = 8'hBE; b[2] = 8'hAD; b[3] = 8'hDE;
      uart_xfer(3'd4, b, 4, 3, "deadbeef");
   endtask

   task automatic test_uart_len0();
      logic [7:0] b [4];
      bit bad = 1'b0;
      b[0] = 8'h41; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
      uart_xfer(3'd0, b, 1, 0, "len0");
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h42;
      repeat (4) begin
         @(negedge clk);
         if (bus.rx_ready !== 1'b0 || bus.reg_we !== 1'b0 || bus.data !== 32'h41) bad = 1'b1;
      end
      bus.rx_valid = 1'b0;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL len0_surplus got rdy=%b we=%b data=%h want 0 0 00000041",
                  bus.rx_ready, bus.reg_we, bus.data);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b [4];
      b[0] = 8'h7F; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
      uart_xfer(3'd2, b, 1, 0, "timeout");
      uart_xfer(3'd3, b, 0, 0, "timeout_empty");
   endtask

   task automatic test_reset_mid_rx();
      bit saw_we = 1'b0;
      @(negedge clk);
      bus.wb_valid = 1'b1;
      bus.wb_sel = 3'd4;
      bus.rx_len = 3'd4;
      @(negedge clk);
      bus.wb_valid = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h11;
      @(negedge clk);
      bus.rx_data = 8'h22;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.pc_enable !== 1'b1 || bus.rx_ready !== 1'b0 || bus.data !== 32'h0 ||
          bus.reg_we !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got pce=%b rdy=%b data=%h we=%b want 1 0 0 0",
                  bus.pc_enable, bus.rx_ready, bus.data, bus.reg_we);
      end
      exp_data = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus.reg_we !== 1'b0 || bus.pc_enable !== 1'b1) saw_we = 1'b1;
      end
      checks++;
      if (saw_we) begin
         errors++;
         $display("FAIL mid_rst_after got we/pce activity want we=0 pce=1");
      end
   endtask

   task automatic test_uart_random();
      logic [7:0] b [4];
      logic [2:0] len_in;
      int L;
      int nsend;
      for (int it = 0; it < 10; it++) begin
         len_in = 3'($urandom_range(0, 7));
         L = (len_in == 0) ? 1 : ((len_in > 4) ? 4 : int'(len_in));
         for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
         nsend = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : L;
         uart_xfer(len_in, b, nsend, $urandom_range(0, 4), "uart_rand");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu();
      test_link();
      test_sources_random();
      test_back_to_back();
      test_uart_word();
      test_uart_len0();
      test_timeout();
      test_reset_mid_rx();
      test_uart_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised register-writeback stage of the core. It selects the destination-register value from memory, ALU, FPU or link (pc+1), or from UART receive bytes. UART reads assemble 1..DATA_WIDTH/8 bytes little-endian into one word. The stage stalls the PC while bytes are outstanding and has an optional receive timeout.

Parameters:
DATA_WIDTH, 32, register/data width; must be a multiple of 8.
PC_WIDTH, 2, program-counter width.
BYTES_PER_WORD, DATA_WIDTH/8, maximum bytes per UART read.
TIMEOUT_CYCLES, 0, idle cycles between bytes before a forced commit; 0 disables the timeout.

Ports:
CLK  input  1  clock.
reset  input  1  asynchronous, active-high reset.
wb_valid  input  1  one-cycle strobe: a new instruction is in writeback.
wb_sel  input  3  source: 0 none, 1 mem, 2 alu, 3 link, 4 uart, 5 fpu, 6/7 reserved (no write).
rx_len  input  $clog2(BYTES_PER_WORD+1)  byte count for a UART read; 0 is treated as 1; values above BYTES_PER_WORD are clamped.
read_data  input  DATA_WIDTH  memory load data.
alu_result  input  DATA_WIDTH  ALU result.
fpu_result  input  DATA_WIDTH  FPU result.
pc  input  PC_WIDTH  PC of the writeback instruction.
rx_data  input  8  UART receive byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  byte accepted when rx_valid && rx_ready.
reg_we  output  1  register-file write enable, one-cycle pulse.
data  output  DATA_WIDTH  write data; held until the next write.
pc_enable  output  1  0 stalls fetch and the pipeline.
timeout_err  output  1  one-cycle pulse when a UART read commits because of timeout.

Behaviour:
- Reset (asynchronous): reg_we=0, data=0, pc_enable=1, timeout_err=0, state=IDLE, byte counter=0, accumulator=0, timeout counter=0. rx_ready=0 because it is combinational, equal to (state==RX).
- A reset mid-read discards the partial word and does not pulse reg_we.
- States: IDLE, RX, COMMIT.
- IDLE, wb_valid with sel in {1,2,3,5}: next cycle data=selected value and reg_we=1 for exactly one cycle. Latency is 1. The state stays IDLE.
- Link value: (pc+1) mod 2^PC_WIDTH, zero-extended to DATA_WIDTH. For example, pc=3 with PC_WIDTH=2 writes 0.
- IDLE, wb_valid with sel 0/6/7: no write; reg_we stays 0 and data is unchanged.
- IDLE, wb_valid with sel=4: go to RX. At the next edge: pc_enable=0, byte counter=0, accumulator=0, timeout counter=0. The effective length L is latched at this point.
- RX: each handshake stores rx_data into accumulator bits [8k+7:8k], where k is the counter; then counter++ and the timeout counter is cleared. Unfilled upper bytes stay zero.
- RX, handshake on byte L-1: go to COMMIT. At the next edge: data=assembled word, reg_we=1, pc_enable=1.
- RX, TIMEOUT_CYCLES>0: the timeout counter increments on each cycle without a handshake. When it reaches TIMEOUT_CYCLES, go to COMMIT with the partial word (zero-filled), and timeout_err=1 in the same cycle as reg_we.
  - With zero bytes received, the committed word is 0.
- COMMIT: lasts one cycle. reg_we and timeout_err return to 0 and the state returns to IDLE. rx_ready=0 in COMMIT and IDLE, so surplus bytes stay in the UART.
- wb_valid while in RX or COMMIT is a protocol violation: ignore it and assert in simulation. The pipeline is frozen by pc_enable=0, so this cannot legally occur.
- rx_valid in IDLE is ignored and no byte is consumed.
- Back-to-back wb_valid in IDLE (non-UART) yields back-to-back reg_we pulses, each carrying its own data.

Decomposition:
- Shared package wb_pkg:
  - wb_sel_e enum (WB_NONE, WB_MEM, WB_ALU, WB_LINK, WB_UART, WB_FPU).
  - wb_state_e enum (IDLE, RX, COMMIT).
  - WB_SEL_W=3.
- Sub-module uart_word_assembler holds the byte counter, accumulator, length clamp and timeout counter. It exposes done, timed_out and word. writeback_stage contains the FSM and source mux.

Test Plan:
- Defaults; wb_valid, sel=2, alu_result=32'h1234_5678 -> next cycle reg_we=1 and data=32'h1234_5678; one cycle later reg_we=0 and data is held.
- sel=3, pc=2'b11 -> data=0 and reg_we pulses; with pc=2'b01 -> data=2.
- sel=4, rx_len=4, bytes 8'hEF,8'hBE,8'hAD,8'hDE with 3 idle cycles between each -> pc_enable=0 throughout, then reg_we=1, data=32'hDEAD_BEEF and pc_enable=1 the cycle after the last handshake.
- sel=4, rx_len=0 -> exactly one byte 8'h41 consumed, data=32'h0000_0041; a second rx_valid byte is not accepted (rx_ready=0).
- TIMEOUT_CYCLES=10, sel=4, rx_len=2, one byte 8'h7F then silence -> after 10 idle cycles: reg_we=1, timeout_err=1, data=32'h0000_007F, pc_enable=1.
- Reset asserted mid-RX after 2 of 4 bytes -> immediately pc_enable=1, rx_ready=0, data=0, and no reg_we pulse after release.
